// File: rtl/count_pkg.sv
// Shared types and helpers for the count-cell family (count_n and friends).
// count_n honours the optional COUNT_N_AUTO_RELOAD_EN build macro.
package count_pkg;

    typedef enum logic {
        COUNT_UP   = 1'b0,
        COUNT_DOWN = 1'b1
    } count_dir_e;

    // Unknown load bits become a random bit in simulation; in hardware this is a wire.
    function automatic logic count_rand_x(input logic d);
        logic r;
        r = d;
`ifndef SYNTHESIS
        if ($isunknown(d)) begin
            r = 1'($random);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/count_term_detect.sv
// Terminal-value compare for a count cell: flags the state that wraps on the next
// counting edge, given the current direction and enable.
module count_term_detect
    import count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    input  logic             en,
    output logic             wrap
);

    count_dir_e dir_e;

    always_comb begin
        dir_e = count_dir_e'(dir);
        wrap  = 1'b0;
        if (en) begin
            wrap = (dir_e == COUNT_DOWN) ? (cnt == '0) : (&cnt);
        end
    end

endmodule

// File: rtl/count_n.sv
// WIDTH-bit loadable up/down count cell counting on negedge nclk, with async load,
// terminal count and registered overflow pulse. Optional macro: COUNT_N_AUTO_RELOAD_EN.
module count_n
    import count_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RESET_Q = '0
) (
    input  logic             nclk,
    input  logic             nreset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] load_val;
    logic             ovf_q;
    logic             ovf_d;
    logic             wrap;

    count_term_detect #(
        .WIDTH (WIDTH)
    ) u_term (
        .cnt  (cnt_q),
        .dir  (dir),
        .en   (en),
        .wrap (wrap)
    );

    always_comb begin
        load_val = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_val[i] = count_rand_x(d[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = wrap;
        if (en) begin
            if (wrap) begin
`ifdef COUNT_N_AUTO_RELOAD_EN
                cnt_d = load_val;
`else
                cnt_d = (count_dir_e'(dir) == COUNT_DOWN) ? '1 : '0;
`endif
            end else if (count_dir_e'(dir) == COUNT_DOWN) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // Reset beats load, load beats counting; load is level-sensitive via the q mux.
    always_ff @(negedge nclk or negedge nreset or posedge load) begin
        if (!nreset) begin
            cnt_q <= RESET_Q;
        end else if (load) begin
            cnt_q <= load_val;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(negedge nclk or negedge nreset or posedge load) begin
        if (!nreset) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign q   = (load && nreset) ? load_val : cnt_q;
    assign tc  = load ? 1'b0 : wrap;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_count_n.sv
// Self-checking bench for count_n (WIDTH=8, RESET_Q=0): directed vector table,
// hand-written reset/X-load sequences and a randomized run against an arithmetic model.
module tb_count_n;

`ifdef COUNT_N_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       en;
        logic       dir;
        logic [7:0] q;
        logic       tc;
        logic       ovf;
    } vec_t;

    logic       nclk;
    logic       nreset;
    logic       load;
    logic [7:0] d;
    logic       en;
    logic       dir;
    logic [7:0] q;
    logic       tc;
    logic       ovf;

    int n_checks;
    int n_errors;

    vec_t vecs[25];

    int   m_cnt;
    bit   m_ovf;

    count_n #(
        .WIDTH   (8),
        .RESET_Q (8'h00)
    ) dut (
        .nclk   (nclk),
        .nreset (nreset),
        .load   (load),
        .d      (d),
        .en     (en),
        .dir    (dir),
        .q      (q),
        .tc     (tc),
        .ovf    (ovf)
    );

    initial nclk = 1'b1;
    always #5 nclk = ~nclk;

    function automatic vec_t mk(input logic l, input logic [7:0] dd, input logic e,
                                input logic dr, input logic [7:0] eq, input logic etc,
                                input logic eovf);
        vec_t v;
        v.ld  = l;
        v.d   = dd;
        v.en  = e;
        v.dir = dr;
        v.q   = eq;
        v.tc  = etc;
        v.ovf = eovf;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives inputs just after a posedge so the next negedge sees them settled.
    task automatic applyStimulus(input logic l, input logic [7:0] dd, input logic e,
                                 input logic dr);
        @(posedge nclk);
        load = l;
        d    = dd;
        en   = e;
        dir  = dr;
        #1;
    endtask

    // Model of what the next counting edge does, in plain modulo arithmetic.
    task automatic modelEdge(input logic l, input logic [7:0] dd, input logic e,
                             input logic dr);
        bit w;
        if (l) begin
            m_cnt = dd;
            m_ovf = 1'b0;
        end else if (e) begin
            w     = dr ? (m_cnt == 0) : (m_cnt == 255);
            m_ovf = w;
            if (w && AR) m_cnt = dd;
            else         m_cnt = (m_cnt + (dr ? 255 : 1)) % 256;
        end else begin
            m_ovf = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] dx;
        logic       rl;
        logic [7:0] rd;
        logic       re;
        logic       rdir;
        logic [7:0] exp_q;
        logic       exp_tc;

        n_checks = 0;
        n_errors = 0;
        m_cnt    = 0;
        m_ovf    = 1'b0;

        vecs[0]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 8'h00, 1, 0, 8'h01, 0, 0);
        vecs[2]  = mk(0, 8'h00, 1, 0, 8'h02, 0, 0);
        vecs[3]  = mk(0, 8'h00, 1, 0, 8'h03, 0, 0);
        vecs[4]  = mk(1, 8'hFE, 1, 0, 8'hFE, 0, 0);
        vecs[5]  = mk(0, 8'hFE, 1, 0, 8'hFE, 0, 0);
        vecs[6]  = mk(0, 8'hFE, 1, 0, 8'hFF, 1, 0);
        vecs[7]  = mk(0, 8'hFE, 1, 0, AR ? 8'hFE : 8'h00, 0, 1);
        vecs[8]  = mk(0, 8'hFE, 1, 0, AR ? 8'hFF : 8'h01, AR, 0);
        vecs[9]  = mk(1, 8'h01, 1, 1, 8'h01, 0, 0);
        vecs[10] = mk(0, 8'h01, 1, 1, 8'h01, 0, 0);
        vecs[11] = mk(0, 8'h01, 1, 1, 8'h00, 1, 0);
        vecs[12] = mk(0, 8'h01, 1, 1, AR ? 8'h01 : 8'hFF, 0, 1);
        vecs[13] = mk(1, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[14] = mk(0, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[15] = mk(0, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[16] = mk(0, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[17] = mk(0, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[18] = mk(1, 8'h7F, 1, 0, 8'h7F, 0, 0);
        vecs[19] = mk(0, 8'h7F, 0, 0, 8'h7F, 0, 0);
        vecs[20] = mk(1, 8'hFF, 0, 0, 8'hFF, 0, 0);
        vecs[21] = mk(0, 8'hFF, 0, 0, 8'hFF, 0, 0);
        vecs[22] = mk(0, 8'hFF, 1, 0, 8'hFF, 1, 0);
        vecs[23] = mk(0, 8'hFF, 0, 0, AR ? 8'hFF : 8'h00, 0, 1);
        vecs[24] = mk(0, 8'hFF, 0, 0, AR ? 8'hFF : 8'h00, 0, 0);

        // Reset is asynchronous and holds the count through a negedge.
        nreset = 1'b0;
        load   = 1'b0;
        d      = 8'h00;
        en     = 1'b1;
        dir    = 1'b0;
        #2;
        checkOutput("reset_q", q, 8'h00);
        checkOutput("reset_ovf", {7'b0, ovf}, 8'h00);
        #5;
        checkOutput("reset_hold_q", q, 8'h00);
        #1;
        nreset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].ld, vecs[i].d, vecs[i].en, vecs[i].dir);
            checkOutput($sformatf("vec%0d_q", i), q, vecs[i].q);
            checkOutput($sformatf("vec%0d_tc", i), {7'b0, tc}, {7'b0, vecs[i].tc});
            checkOutput($sformatf("vec%0d_ovf", i), {7'b0, ovf}, {7'b0, vecs[i].ovf});
        end

        // Async reset mid-count while ovf is high, then load blocked by reset.
        applyStimulus(1, 8'h00, 0, 1);
        checkOutput("rst_seq_load_q", q, 8'h00);
        applyStimulus(0, 8'h00, 1, 1);
        checkOutput("rst_seq_tc", {7'b0, tc}, 8'h01);
        applyStimulus(0, 8'h00, 1, 1);
        checkOutput("rst_seq_wrap_q", q, AR ? 8'h00 : 8'hFF);
        checkOutput("rst_seq_wrap_ovf", {7'b0, ovf}, 8'h01);
        #1;
        nreset = 1'b0;
        #1;
        checkOutput("rst_seq_async_q", q, 8'h00);
        checkOutput("rst_seq_async_ovf", {7'b0, ovf}, 8'h00);
        load = 1'b1;
        d    = 8'hAA;
        #1;
        checkOutput("rst_seq_load_blocked_q", q, 8'h00);
        @(negedge nclk);
        #1;
        checkOutput("rst_seq_edge_q", q, 8'h00);
        checkOutput("rst_seq_edge_ovf", {7'b0, ovf}, 8'h00);
        load = 1'b0;
        @(posedge nclk);
        nreset = 1'b1;

        // Load with unknown upper nibble, then count from whatever it became.
        dx = 8'bxxxx_0000;
        applyStimulus(1, dx, 0, 0);
        checkOutput("xload_known", {7'b0, $isunknown(q)}, 8'h00);
        checkOutput("xload_low", {4'h0, q[3:0]}, 8'h00);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("xload_hold_low", {4'h0, q[3:0]}, 8'h00);
        checkOutput("xload_hold_known", {7'b0, $isunknown(q)}, 8'h00);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("xcount1_low", {4'h0, q[3:0]}, 8'h01);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("xcount2_low", {4'h0, q[3:0]}, 8'h02);

        // Randomized run; the first step is a load so the model starts in sync.
        for (int i = 0; i < 300; i++) begin
            rl   = (i == 0) || ($urandom_range(0, 15) == 0);
            rd   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00)
                                               : 8'($urandom);
            re   = ($urandom_range(0, 3) != 0);
            rdir = 1'($urandom);
            applyStimulus(rl, rd, re, rdir);
            exp_q  = rl ? rd : 8'(m_cnt);
            exp_tc = !rl && re && (rdir ? (m_cnt == 0) : (m_cnt == 255));
            checkOutput($sformatf("rand%0d_q", i), q, exp_q);
            checkOutput($sformatf("rand%0d_tc", i), {7'b0, tc}, {7'b0, exp_tc});
            checkOutput($sformatf("rand%0d_ovf", i), {7'b0, ovf},
                        {7'b0, (rl ? 1'b0 : m_ovf)});
            modelEdge(rl, rd, re, rdir);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
